// File: rtl/exc_ctrl_if.sv
// Bundle of the exc_ctrl signals that travel between the CP0 and MEM-stage side and the arbiter.
// The slave modport is the arbiter's view; the master modport is its environment.
interface exc_ctrl_if;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        timer_int_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_data_i;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delay_slot_i;
    logic [4:0]  mem_exc_i;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        exc_commit_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_epc_o;
    logic        exc_epc_we_o;
    logic        exc_bd_o;
    logic        eret_o;
    logic        busy_o;

    modport slave (
        input  status_i, cause_i, epc_i, timer_int_i,
        input  cp0_we_i, cp0_waddr_i, cp0_data_i,
        input  mem_valid_i, mem_pc_i, mem_in_delay_slot_i, mem_exc_i,
        output flush_o, new_pc_o, exc_commit_o, exc_code_o, exc_epc_o,
        output exc_epc_we_o, exc_bd_o, eret_o, busy_o
    );

    modport master (
        output status_i, cause_i, epc_i, timer_int_i,
        output cp0_we_i, cp0_waddr_i, cp0_data_i,
        output mem_valid_i, mem_pc_i, mem_in_delay_slot_i, mem_exc_i,
        input  flush_o, new_pc_o, exc_commit_o, exc_code_o, exc_epc_o,
        input  exc_epc_we_o, exc_bd_o, eret_o, busy_o
    );
endinterface

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt arbiter: picks interrupt, exception or ERET, then
// issues a registered flush/redirect and a one-cycle CP0 commit, followed by a drain window.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    exc_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    state_t      state;
    logic [3:0]  drain_cnt;

    logic        fwd_status;
    logic        fwd_cause;
    logic        fwd_epc;
    logic [7:0]  status_im;
    logic        status_ie;
    logic        status_exl;
    logic [7:0]  cause_ip;
    logic [7:0]  ip_eff;
    logic [31:0] epc_eff;
    logic        int_pending;

    logic        take_exc;
    logic        take_eret;
    logic [4:0]  dec_code;
    logic [31:0] dec_epc;

    assign fwd_status = bus.cp0_we_i && (bus.cp0_waddr_i == 5'd12);
    assign fwd_cause  = bus.cp0_we_i && (bus.cp0_waddr_i == 5'd13);
    assign fwd_epc    = bus.cp0_we_i && (bus.cp0_waddr_i == 5'd14);

    // An mtc0 still in WB must win over the stale CP0 register values. Only the
    // software-writable IP bits (9:8) of Cause influence the interrupt decision.
    always_comb begin
        status_im  = bus.status_i[15:8];
        status_ie  = bus.status_i[0];
        status_exl = bus.status_i[1];
        cause_ip   = bus.cause_i[15:8];
        epc_eff    = bus.epc_i;
        if (fwd_status) begin
            status_im  = bus.cp0_data_i[15:8];
            status_ie  = bus.cp0_data_i[0];
            status_exl = bus.cp0_data_i[1];
        end
        if (fwd_cause) begin
            cause_ip[1:0] = bus.cp0_data_i[9:8];
        end
        if (fwd_epc) begin
            epc_eff = bus.cp0_data_i;
        end
    end

    assign ip_eff      = {cause_ip[7] | bus.timer_int_i, cause_ip[6:0]};
    assign int_pending = (|(ip_eff & status_im)) && status_ie && !status_exl;

    assign dec_epc = bus.mem_in_delay_slot_i ? (bus.mem_pc_i - 32'd4) : bus.mem_pc_i;

    // mem_exc_i is {eret, ov, ri, bp, syscall}; interrupts outrank every synchronous cause.
    always_comb begin
        take_exc  = 1'b0;
        take_eret = 1'b0;
        dec_code  = CODE_INT;
        if (state == IDLE && bus.mem_valid_i) begin
            if (int_pending) begin
                take_exc = 1'b1;
                dec_code = CODE_INT;
            end else if (bus.mem_exc_i[0]) begin
                take_exc = 1'b1;
                dec_code = CODE_SYS;
            end else if (bus.mem_exc_i[1]) begin
                take_exc = 1'b1;
                dec_code = CODE_BP;
            end else if (bus.mem_exc_i[2]) begin
                take_exc = 1'b1;
                dec_code = CODE_RI;
            end else if (bus.mem_exc_i[3]) begin
                take_exc = 1'b1;
                dec_code = CODE_OV;
            end else if (bus.mem_exc_i[4]) begin
                take_eret = 1'b1;
            end
        end
    end

    // Pulses live only in FLUSH; redirect PC and exc_* fields hold until the next decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            drain_cnt        <= 4'd0;
            bus.flush_o      <= 1'b0;
            bus.new_pc_o     <= 32'd0;
            bus.exc_commit_o <= 1'b0;
            bus.exc_code_o   <= 5'd0;
            bus.exc_epc_o    <= 32'd0;
            bus.exc_epc_we_o <= 1'b0;
            bus.exc_bd_o     <= 1'b0;
            bus.eret_o       <= 1'b0;
            bus.busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_exc) begin
                        state            <= FLUSH;
                        bus.flush_o      <= 1'b1;
                        bus.new_pc_o     <= EXC_VECTOR;
                        bus.exc_commit_o <= 1'b1;
                        bus.exc_code_o   <= dec_code;
                        bus.exc_epc_o    <= dec_epc;
                        bus.exc_epc_we_o <= !status_exl;
                        bus.exc_bd_o     <= bus.mem_in_delay_slot_i;
                        bus.busy_o       <= 1'b1;
                    end else if (take_eret) begin
                        state            <= FLUSH;
                        bus.flush_o      <= 1'b1;
                        bus.new_pc_o     <= epc_eff;
                        bus.eret_o       <= 1'b1;
                        bus.busy_o       <= 1'b1;
                    end
                end
                FLUSH: begin
                    state            <= DRAIN;
                    drain_cnt        <= DRAIN_INIT;
                    bus.flush_o      <= 1'b0;
                    bus.exc_commit_o <= 1'b0;
                    bus.eret_o       <= 1'b0;
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state      <= IDLE;
                        bus.busy_o <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: begin
                    state            <= IDLE;
                    drain_cnt        <= 4'd0;
                    bus.flush_o      <= 1'b0;
                    bus.exc_commit_o <= 1'b0;
                    bus.eret_o       <= 1'b0;
                    bus.busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed vectors push expected redirects, a negedge
// monitor pops and compares whenever flush_o is seen.
module tb_exc_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic        commit;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        epc_we;
        logic        bd;
        logic        eret;
        logic        chk_epc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    exc_ctrl_if bus ();

    exc_ctrl #(.EXC_VECTOR(32'hBFC00380), .DRAIN_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t excExp(input logic [4:0] code, input logic [31:0] epc,
                                    input logic we, input logic bd, input logic chk_epc);
        exp_t e;
        e.pc = 32'hBFC00380; e.commit = 1'b1; e.code = code; e.epc = epc;
        e.epc_we = we; e.bd = bd; e.eret = 1'b0; e.chk_epc = chk_epc;
        return e;
    endfunction

    function automatic exp_t eretExp(input logic [31:0] pc);
        exp_t e;
        e.pc = pc; e.commit = 1'b0; e.code = 5'd0; e.epc = 32'd0;
        e.epc_we = 1'b0; e.bd = 1'b0; e.eret = 1'b1; e.chk_epc = 1'b0;
        return e;
    endfunction

    // Monitor: every flush must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.flush_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_flush actual=1 required=0 new_pc=%h", bus.new_pc_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("new_pc", bus.new_pc_o, e.pc);
                checkOutput("exc_commit", 32'(bus.exc_commit_o), 32'(e.commit));
                checkOutput("eret", 32'(bus.eret_o), 32'(e.eret));
                if (e.commit) begin
                    checkOutput("exc_code", 32'(bus.exc_code_o), 32'(e.code));
                    checkOutput("epc_we", 32'(bus.exc_epc_we_o), 32'(e.epc_we));
                    if (e.chk_epc) begin
                        checkOutput("exc_epc", bus.exc_epc_o, e.epc);
                        checkOutput("exc_bd", 32'(bus.exc_bd_o), 32'(e.bd));
                    end
                end
            end
        end
    end

    task automatic idleInputs();
        bus.mem_valid_i         = 1'b0;
        bus.mem_exc_i           = 5'd0;
        bus.mem_in_delay_slot_i = 1'b0;
        bus.cp0_we_i            = 1'b0;
        bus.cp0_waddr_i         = 5'd0;
        bus.cp0_data_i          = 32'd0;
        bus.timer_int_i         = 1'b0;
    endtask

    // Inputs are already driven by the caller; hold them for one clock edge.
    task automatic applyStimulus(input bit expect_flush, input exp_t e);
        if (expect_flush) sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_flush"}, 32'(bus.flush_o), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        checkOutput({tag, "_commit"}, 32'(bus.exc_commit_o), 32'd0);
        checkOutput({tag, "_eret"}, 32'(bus.eret_o), 32'd0);
        checkOutput({tag, "_new_pc"}, bus.new_pc_o, 32'd0);
        checkOutput({tag, "_code"}, 32'(bus.exc_code_o), 32'd0);
        checkOutput({tag, "_epc"}, bus.exc_epc_o, 32'd0);
    endtask

    exp_t none;

    initial begin
        int busy_cnt;
        checks   = 0;
        failures = 0;
        none     = eretExp(32'd0);
        rst      = 1'b1;
        bus.status_i = 32'd0;
        bus.cause_i  = 32'd0;
        bus.epc_i    = 32'd0;
        bus.mem_pc_i = 32'd0;
        idleInputs();
        waitCycles(2);
        checkAllZero("reset");
        rst = 1'b0;
        waitCycles(1);

        // Pending timer interrupt is held off while MEM holds a bubble.
        bus.status_i = 32'h0000FF01;
        bus.timer_int_i = 1'b1;
        bus.mem_pc_i = 32'h80001000;
        applyStimulus(1'b0, none);
        applyStimulus(1'b0, none);
        bus.mem_valid_i = 1'b1;
        applyStimulus(1'b1, excExp(5'd0, 32'h80001000, 1'b1, 1'b0, 1'b1));
        idleInputs();
        waitCycles(6);

        // Syscall in a delay slot; busy window length, and a repeat syscall during DRAIN is ignored.
        bus.status_i = 32'h00000000;
        bus.mem_valid_i = 1'b1;
        bus.mem_in_delay_slot_i = 1'b1;
        bus.mem_pc_i = 32'h80002004;
        bus.mem_exc_i = 5'b00001;
        applyStimulus(1'b1, excExp(5'd8, 32'h80002000, 1'b1, 1'b1, 1'b1));
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy_o !== 1'b1) break;
            busy_cnt++;
            @(negedge clk);
        end
        idleInputs();
        checkOutput("busy_cycles", 32'(busy_cnt), 32'd4);
        waitCycles(3);

        // ERET with EPC forwarded from an in-flight mtc0.
        bus.epc_i = 32'd0;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h80002800;
        bus.mem_exc_i = 5'b10000;
        bus.cp0_we_i = 1'b1;
        bus.cp0_waddr_i = 5'd14;
        bus.cp0_data_i = 32'h80003000;
        applyStimulus(1'b1, eretExp(32'h80003000));
        idleInputs();
        waitCycles(6);

        // mtc0 clearing IE masks the pending interrupt; then ri under the same masking.
        bus.status_i = 32'h0000FF01;
        bus.timer_int_i = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h80004000;
        bus.cp0_we_i = 1'b1;
        bus.cp0_waddr_i = 5'd12;
        bus.cp0_data_i = 32'h0000FF00;
        applyStimulus(1'b0, none);
        bus.mem_exc_i = 5'b00100;
        applyStimulus(1'b1, excExp(5'd10, 32'h80004000, 1'b1, 1'b0, 1'b1));
        idleInputs();
        waitCycles(6);

        // EXL already set: interrupt suppressed, ov taken without EPC write.
        bus.status_i = 32'h0000FF03;
        bus.timer_int_i = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h80005000;
        bus.mem_exc_i = 5'b01000;
        applyStimulus(1'b1, excExp(5'd12, 32'h80005000, 1'b0, 1'b0, 1'b0));
        idleInputs();
        waitCycles(6);

        // eret together with ov: ov wins.
        bus.status_i = 32'h00000000;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h80006000;
        bus.mem_exc_i = 5'b11000;
        applyStimulus(1'b1, excExp(5'd12, 32'h80006000, 1'b1, 1'b0, 1'b1));
        idleInputs();
        waitCycles(6);

        // Hardware IP2 interrupt beats a syscall in a delay slot.
        bus.status_i = 32'h00000401;
        bus.cause_i = 32'h00000400;
        bus.mem_valid_i = 1'b1;
        bus.mem_in_delay_slot_i = 1'b1;
        bus.mem_pc_i = 32'h80007004;
        bus.mem_exc_i = 5'b00001;
        applyStimulus(1'b1, excExp(5'd0, 32'h80007000, 1'b1, 1'b1, 1'b1));
        idleInputs();
        bus.cause_i = 32'd0;
        waitCycles(6);

        // Software interrupt raised by an mtc0 to Cause in the same cycle.
        bus.status_i = 32'h00000101;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h80008000;
        bus.cp0_we_i = 1'b1;
        bus.cp0_waddr_i = 5'd13;
        bus.cp0_data_i = 32'h00000100;
        applyStimulus(1'b1, excExp(5'd0, 32'h80008000, 1'b1, 1'b0, 1'b1));
        idleInputs();
        bus.status_i = 32'd0;
        waitCycles(6);

        // Reset mid-DRAIN clears everything; a decision right after release is accepted.
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h80009000;
        bus.mem_exc_i = 5'b00001;
        applyStimulus(1'b1, excExp(5'd8, 32'h80009000, 1'b1, 1'b0, 1'b1));
        idleInputs();
        @(negedge clk);
        checkOutput("drain_busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        #1;
        checkAllZero("mid_drain_reset");
        @(negedge clk);
        rst = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i = 32'h8000A000;
        bus.mem_exc_i = 5'b00010;
        applyStimulus(1'b1, excExp(5'd9, 32'h8000A000, 1'b1, 1'b0, 1'b1));
        idleInputs();
        waitCycles(6);

        checkOutput("pending_expectations", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
